// File: rtl/freq_gen_pkg.sv
// Shared types and elaboration-time tuning-word helpers for the multi-channel frequency generator.
package freq_gen_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StMul,
    StWrite
  } arb_state_e;

  // Word that yields low_freq at the given clock rate, floor-truncated.
  function automatic longint unsigned calc_tw_low(input longint unsigned low_freq,
                                                  input longint unsigned clock_freq,
                                                  input int unsigned acc_bits);
    return (low_freq << acc_bits) / clock_freq;
  endfunction

  // Word increment per code LSB across the full code range, floor-truncated.
  function automatic longint unsigned calc_tw_step(input longint unsigned high_freq,
                                                   input longint unsigned low_freq,
                                                   input longint unsigned clock_freq,
                                                   input int unsigned input_bits,
                                                   input int unsigned acc_bits);
    return ((high_freq - low_freq) << acc_bits) /
           (clock_freq * ((64'd1 << input_bits) - 64'd1));
  endfunction

endpackage

// File: rtl/freq_tw_mult.sv
// Sequential shift-add multiplier producing TW_LOW + value * TW_STEP, one code bit per cycle.
module freq_tw_mult #(
  parameter int unsigned         INPUT_BITS = 8,
  parameter int unsigned         ACC_BITS   = 32,
  parameter logic [ACC_BITS-1:0] TW_LOW     = '0,
  parameter logic [ACC_BITS-1:0] TW_STEP    = '0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic [INPUT_BITS-1:0] value_i,
  output logic                  done_o,
  output logic [ACC_BITS-1:0]   result_o
);

  localparam int unsigned CntW = $clog2(INPUT_BITS + 1);

  logic [ACC_BITS-1:0]   sum_q, sum_d;
  logic [ACC_BITS-1:0]   mcand_q, mcand_d;
  logic [INPUT_BITS-1:0] mplier_q, mplier_d;
  logic [CntW-1:0]       cnt_q, cnt_d;

  always_comb begin
    sum_d    = sum_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    if (start_i) begin
      sum_d    = TW_LOW;
      mcand_d  = TW_STEP;
      mplier_d = value_i;
      cnt_d    = CntW'(INPUT_BITS);
    end else if (cnt_q != '0) begin
      if (mplier_q[0]) begin
        sum_d = sum_q + mcand_q;
      end
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sum_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      sum_q    <= sum_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

  // Asserted during the final iteration; result_o is complete on the following cycle.
  assign done_o   = (cnt_q == CntW'(1));
  assign result_o = sum_q;

endmodule

// File: rtl/multi_frequency_module.sv
// Multi-channel phase-continuous NCO square-wave generator with a shared round-robin multiplier.
// Optional FREQ_GEN_PULSE_EN adds PULSE_OUT, a one-cycle strobe on each accumulator wrap.
module multi_frequency_module
  import freq_gen_pkg::*;
#(
  parameter longint unsigned CLOCK_FREQ = 50_000_000,
  parameter longint unsigned LOW_FREQ   = 1_000,
  parameter longint unsigned HIGH_FREQ  = 20_000_000,
  parameter int unsigned     INPUT_BITS = 8,
  parameter int unsigned     CHANNELS   = 4,
  parameter int unsigned     ACC_BITS   = 32
) (
  input  logic                           CLK,
  input  logic                           RST_N,
  input  logic [CHANNELS*INPUT_BITS-1:0] INPUT_VALUE,
  input  logic [CHANNELS-1:0]            VALUE_VALID,
  output logic [CHANNELS-1:0]            VALUE_READY,
  input  logic [CHANNELS-1:0]            ENABLE,
`ifdef FREQ_GEN_PULSE_EN
  output logic [CHANNELS-1:0]            PULSE_OUT,
`endif
  output logic [CHANNELS-1:0]            FREQ_OUT
);

  localparam int unsigned ChW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam longint unsigned TwLowL  = calc_tw_low(LOW_FREQ, CLOCK_FREQ, ACC_BITS);
  localparam longint unsigned TwStepL = calc_tw_step(HIGH_FREQ, LOW_FREQ, CLOCK_FREQ,
                                                     INPUT_BITS, ACC_BITS);
  localparam logic [ACC_BITS-1:0] TwLow  = ACC_BITS'(TwLowL);
  localparam logic [ACC_BITS-1:0] TwStep = ACC_BITS'(TwStepL);

  function automatic logic [ChW-1:0] rr_index(input logic [ChW-1:0] base,
                                              input int unsigned off);
    return ChW'((32'(base) + off) % CHANNELS);
  endfunction

  logic [CHANNELS-1:0]   pend_valid_q, pend_valid_d;
  logic [INPUT_BITS-1:0] pend_code_q [CHANNELS];
  logic [INPUT_BITS-1:0] pend_code_d [CHANNELS];
  logic [ACC_BITS-1:0]   shadow_q [CHANNELS];
  logic [ACC_BITS-1:0]   shadow_d [CHANNELS];
  logic [ACC_BITS-1:0]   active_q [CHANNELS];
  logic [ACC_BITS-1:0]   active_d [CHANNELS];
  logic [ACC_BITS-1:0]   acc_q [CHANNELS];
  logic [ACC_BITS-1:0]   acc_d [CHANNELS];
  logic [ACC_BITS:0]     add_w [CHANNELS];
  logic [CHANNELS-1:0]   freq_q, freq_d;
  logic [CHANNELS-1:0]   accept, cand, wrap;

  arb_state_e          state_q, state_d;
  logic [ChW-1:0]      cur_q, cur_d, rr_q, rr_d, pick_idx;
  logic                pick_found, mul_start, mul_done, wr_en;
  logic [ACC_BITS-1:0] mul_result;
  logic [INPUT_BITS-1:0] mul_value;

  assign VALUE_READY = ~pend_valid_q;
  assign accept      = VALUE_VALID & ~pend_valid_q;
  // A code offered this cycle is visible to the arbiter immediately, saving a cycle of latency.
  assign cand        = pend_valid_q | accept;
  assign mul_value   = pend_code_q[cur_q];
  assign FREQ_OUT    = freq_q;

  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (!pick_found && cand[rr_index(rr_q, i)]) begin
        pick_found = 1'b1;
        pick_idx   = rr_index(rr_q, i);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    rr_d      = rr_q;
    mul_start = 1'b0;
    wr_en     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pick_found) begin
          cur_d   = pick_idx;
          state_d = StLoad;
        end
      end
      StLoad: begin
        mul_start = 1'b1;
        state_d   = StMul;
      end
      StMul: begin
        if (mul_done) state_d = StWrite;
      end
      StWrite: begin
        wr_en   = 1'b1;
        rr_d    = rr_index(cur_q, 1);
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  freq_tw_mult #(
    .INPUT_BITS(INPUT_BITS),
    .ACC_BITS  (ACC_BITS),
    .TW_LOW    (TwLow),
    .TW_STEP   (TwStep)
  ) u_mult (
    .clk_i   (CLK),
    .rst_ni  (RST_N),
    .start_i (mul_start),
    .value_i (mul_value),
    .done_o  (mul_done),
    .result_o(mul_result)
  );

  always_comb begin
    pend_valid_d = pend_valid_q;
    wrap         = '0;
    freq_d       = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      pend_code_d[c] = pend_code_q[c];
      shadow_d[c]    = shadow_q[c];
      if (accept[c]) begin
        pend_valid_d[c] = 1'b1;
        pend_code_d[c]  = INPUT_VALUE[c*INPUT_BITS +: INPUT_BITS];
      end
      if (wr_en && (cur_q == ChW'(c))) begin
        pend_valid_d[c] = 1'b0;
        shadow_d[c]     = mul_result;
      end
      add_w[c] = {1'b0, acc_q[c]} + {1'b0, active_q[c]};
      wrap[c]  = ENABLE[c] & add_w[c][ACC_BITS];
      acc_d[c] = ENABLE[c] ? add_w[c][ACC_BITS-1:0] : '0;
      freq_d[c] = ENABLE[c] & add_w[c][ACC_BITS-1];
      // Reading shadow_q means a same-cycle shadow write lands at the following wrap.
      active_d[c] = (wrap[c] || !ENABLE[c]) ? shadow_q[c] : active_q[c];
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= StIdle;
      cur_q        <= '0;
      rr_q         <= '0;
      pend_valid_q <= '0;
      freq_q       <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        pend_code_q[c] <= '0;
        shadow_q[c]    <= TwLow;
        active_q[c]    <= TwLow;
        acc_q[c]       <= '0;
      end
    end else begin
      state_q      <= state_d;
      cur_q        <= cur_d;
      rr_q         <= rr_d;
      pend_valid_q <= pend_valid_d;
      freq_q       <= freq_d;
      for (int c = 0; c < CHANNELS; c++) begin
        pend_code_q[c] <= pend_code_d[c];
        shadow_q[c]    <= shadow_d[c];
        active_q[c]    <= active_d[c];
        acc_q[c]       <= acc_d[c];
      end
    end
  end

`ifdef FREQ_GEN_PULSE_EN
  logic [CHANNELS-1:0] pulse_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pulse_q <= '0;
    end else begin
      pulse_q <= wrap;
    end
  end

  assign PULSE_OUT = pulse_q;
`endif

endmodule

// File: tb/tb_multi_frequency_module.sv
// Scoreboard bench for multi_frequency_module: shadow writes are checked as VALUE_READY returns,
// output rates are checked by counting FREQ_OUT rising edges over fixed windows.
module tb_multi_frequency_module;

  localparam longint unsigned TWL = (64'd1000 << 32) / 64'd50_000_000;
  localparam longint unsigned TWS = (64'd19_999_000 << 32) / (64'd50_000_000 * 64'd255);

  typedef struct {
    int     ch;
    longint cyc;
    longint tw;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] iv;
  logic [3:0]  vv;
  logic [3:0]  rdy;
  logic [3:0]  en;
  logic [3:0]  freq;
`ifdef FREQ_GEN_PULSE_EN
  logic [3:0]  pulse;
`endif

  exp_t   sb_q[$];
  longint cyc;
  int     checks;
  int     errors;
  int     rise_cnt [4];
  int     pulse_cnt;

  multi_frequency_module dut (
    .CLK        (clk),
    .RST_N      (rst_n),
    .INPUT_VALUE(iv),
    .VALUE_VALID(vv),
    .VALUE_READY(rdy),
    .ENABLE     (en),
`ifdef FREQ_GEN_PULSE_EN
    .PULSE_OUT  (pulse),
`endif
    .FREQ_OUT   (freq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    cyc = 0;
    forever @(posedge clk) cyc++;
  end

  function automatic longint tw_of(input int v);
    return longint'(TWL + longint'(v) * TWS);
  endfunction

  task automatic chk_rng(input string name, input longint act, input longint lo,
                         input longint hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic chk(input string name, input longint act, input longint exp);
    chk_rng(name, act, exp, exp);
  endtask

  // Monitor: each VALUE_READY rise marks a completed WRITE and is matched to the queue head.
  initial begin
    logic [3:0] prev;
    exp_t       e;
    prev = 4'hF;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        for (int c = 0; c < 4; c++) begin
          if (rdy[c] && !prev[c]) begin
            if (sb_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL sb_unexpected: ready rose on ch%0d at cycle %0d, required none",
                       c, cyc);
            end else begin
              e = sb_q.pop_front();
              chk("sb_channel", longint'(c), longint'(e.ch));
              chk("sb_cycle", cyc, e.cyc);
              chk("sb_shadow_tw", longint'(dut.shadow_q[c]), e.tw);
            end
          end
        end
      end
      prev = rdy;
    end
  end

  task automatic push_exp(input int ch, input longint at, input int code);
    exp_t e;
    e.ch  = ch;
    e.cyc = at;
    e.tw  = tw_of(code);
    sb_q.push_back(e);
  endtask

  task automatic wait_sb(input int max_cyc);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    chk("sb_drain", longint'(sb_q.size()), 0);
    sb_q.delete();
  endtask

  task automatic run_window(input int len);
    logic [3:0] prev;
    prev = freq;
    pulse_cnt = 0;
    for (int c = 0; c < 4; c++) rise_cnt[c] = 0;
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      for (int c = 0; c < 4; c++) begin
        if (freq[c] && !prev[c]) rise_cnt[c]++;
      end
`ifdef FREQ_GEN_PULSE_EN
      if (pulse[3]) pulse_cnt++;
`endif
      prev = freq;
    end
  endtask

  function automatic longint rate_exp(input int code, input int len);
    return (longint'(len) * tw_of(code)) >>> 32;
  endfunction

  initial begin
    longint e_cyc;
    longint t;
    int     n;
    int     low_cnt;
    longint ex;
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    en     = '0;
    vv     = '0;
    iv     = '0;
    repeat (3) @(negedge clk);
    chk("reset_ready", longint'(rdy), 15);
    chk("reset_freq", longint'(freq), 0);
    chk("reset_shadow0", longint'(dut.shadow_q[0]), longint'(TWL));
    rst_n = 1'b1;
    @(negedge clk);

    // Code 0 everywhere: first half-period of the 1 kHz output.
    en    = 4'hF;
    e_cyc = cyc;
    n = 0;
    while (!freq[0] && n < 30000) begin
      @(negedge clk);
      n++;
    end
    chk("first_rise_ch0", cyc - e_cyc, longint'(((64'd1 << 31) + TWL - 1) / TWL));

    // Code 255 on ch0 mid-period; it must wait for the wrap.
    @(negedge clk);
    t = cyc;
    iv[7:0] = 8'd255;
    vv      = 4'b0001;
    push_exp(0, t + 11, 255);
    @(negedge clk);
    vv      = '0;
    low_cnt = 0;
    for (int i = 0; i < 14; i++) begin
      if (!rdy[0]) low_cnt++;
      @(negedge clk);
    end
    chk_rng("ready_low_ch0", longint'(low_cnt), 10, 11);
    wait_sb(10);
    n = 0;
    while (freq[0] && n < 40000) begin
      @(negedge clk);
      n++;
    end
    chk("wrap_ch0_old_period", cyc - e_cyc, longint'(((64'd1 << 32) + TWL - 1) / TWL));
    run_window(1000);
    ex = rate_exp(255, 1000);
    chk_rng("rate_ch0_code255", longint'(rise_cnt[0]), ex - 1, ex + 1);

    // Reset while the multiplier is busy on ch1.
    @(negedge clk);
    iv[15:8] = 8'd42;
    vv       = 4'b0010;
    @(negedge clk);
    vv = '0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_ready", longint'(rdy), 15);
    chk("async_reset_freq", longint'(freq), 0);
`ifdef FREQ_GEN_PULSE_EN
    chk("async_reset_pulse", longint'(pulse), 0);
`endif
    en = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // All four codes at once while disabled; served 0,1,2,3 every 11 cycles.
    t  = cyc;
    iv = {8'd255, 8'd170, 8'd85, 8'd0};
    vv = 4'hF;
    push_exp(0, t + 11, 0);
    push_exp(1, t + 22, 85);
    push_exp(2, t + 33, 170);
    push_exp(3, t + 44, 255);
    @(negedge clk);
    vv = '0;
    wait_sb(60);
    repeat (2) @(negedge clk);
    chk("disabled_freq", longint'(freq), 0);

    // Enable 1..3: the very first periods must already use the new words.
    en = 4'b1110;
    run_window(1000);
    chk("rate_ch0_disabled", longint'(rise_cnt[0]), 0);
    ex = rate_exp(85, 1000);
    chk_rng("rate_ch1_code85", longint'(rise_cnt[1]), ex - 1, ex + 1);
    ex = rate_exp(170, 1000);
    chk_rng("rate_ch2_code170", longint'(rise_cnt[2]), ex - 1, ex + 1);
    ex = rate_exp(255, 1000);
    chk_rng("rate_ch3_code255", longint'(rise_cnt[3]), ex - 1, ex + 1);
`ifdef FREQ_GEN_PULSE_EN
    chk_rng("pulse_vs_rise_ch3", longint'(pulse_cnt), longint'(rise_cnt[3]) - 1,
            longint'(rise_cnt[3]) + 1);
`endif

    // Dropping ENABLE while high forces FREQ_OUT low at the next edge.
    n = 0;
    while (!freq[3] && n < 20) begin
      @(negedge clk);
      n++;
    end
    en = '0;
    @(negedge clk);
    chk("enable_drop_freq", longint'(freq), 0);

    chk("sb_leftover", longint'(sb_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
